// File: rtl/led_pattern_pkg.sv
// -----------------------------------------------------------------------------
// led_pattern_pkg
// Shared definitions for the LED pattern generator:
//   - mode_t : pattern select encodings (rotate left/right, bounce, blink)
//   - dir_t  : bounce direction flag values
//   - PWM_W  : width of the optional brightness PWM counter and duty input
// -----------------------------------------------------------------------------
package led_pattern_pkg;

   typedef enum logic [1:0] {
      MODE_ROT_L  = 2'd0,
      MODE_ROT_R  = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_BLINK  = 2'd3
   } mode_t;

   typedef enum logic {
      DIR_L = 1'b0,
      DIR_R = 1'b1
   } dir_t;

   localparam int PWM_W = 8;

endpackage

// File: rtl/led_step_timer.sv
// -----------------------------------------------------------------------------
// led_step_timer
// Programmable step timebase. Produces a tick every P cycles while running,
// where P = max(TICK_DIV >> speed, 1). Shared with other board timebases.
//
// Parameters:
//   TICK_DIV : base step period in clk cycles (>= 1)
// Ports:
//   clk   in  1  system clock
//   rst   in  1  asynchronous active-high reset
//   run   in  1  1 = count, 0 = hold the count
//   speed in  2  right-shift applied to TICK_DIV to get the period
//   clear in  1  synchronous counter clear (takes priority over counting)
//   tick  out 1  combinational, high in the cycle the period completes
// -----------------------------------------------------------------------------
module led_step_timer #(
   parameter int TICK_DIV = 10_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic [1:0] speed,
   input  logic       clear,
   output logic       tick
);

   localparam int CW = $clog2(TICK_DIV + 1);
   localparam logic [CW-1:0] DIV = CW'(TICK_DIV);

   logic [CW-1:0] count;
   logic [CW-1:0] shifted;
   logic [CW-1:0] periodM1;

   // Terminal count is period-1, with the period floored at one cycle so the
   // fastest speeds degrade to a tick every cycle. The compare is >= rather
   // than == so that shortening the period mid-count fires on the next cycle
   // instead of wrapping all the way around the counter.
   always_comb begin
      shifted  = DIV >> speed;
      periodM1 = (shifted == '0) ? '0 : shifted - CW'(1);
      tick     = run & (count >= periodM1);
   end

   // Counter advances only while running and restarts from zero after each
   // tick; an external clear (used on pattern reloads) wins over everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (run) begin
         if (tick) begin
            count <= '0;
         end else begin
            count <= count + CW'(1);
         end
      end
   end

endmodule

// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
// LED pattern generator for the board LED banks. Steps one of four patterns
// (rotate left, rotate right, bounce, blink) on every tick of a programmable
// timebase.
//
// Parameters:
//   N_LED    : number of LED outputs (>= 1)
//   TICK_DIV : base step period in clk cycles (>= 1)
// Ports:
//   clk     in  1      system clock
//   rst     in  1      asynchronous active-high reset
//   run_i   in  1      1 = pattern advances, 0 = timebase and pattern freeze
//   mode_i  in  2      0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 BLINK
//   speed_i in  2      step period = max(TICK_DIV >> speed_i, 1)
//   duty_i  in  8      PWM duty (only with LED_PATTERN_PWM_EN)
//   led_o   out N_LED  registered LED drive, 1 = lit
//   step_o  out 1      one-cycle pulse coincident with each pattern update
//
// Build option:
//   LED_PATTERN_PWM_EN : adds duty_i and a free-running 8-bit PWM stage on
//                        led_o; led_o and step_o gain one cycle of latency.
// -----------------------------------------------------------------------------
module led_pattern_gen
   import led_pattern_pkg::*;
#(
   parameter int N_LED    = 4,
   parameter int TICK_DIV = 10_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_i,
   input  logic [1:0]       mode_i,
   input  logic [1:0]       speed_i,
`ifdef LED_PATTERN_PWM_EN
   input  logic [PWM_W-1:0] duty_i,
`endif
   output logic [N_LED-1:0] led_o,
   output logic             step_o
);

   localparam logic [N_LED-1:0] SEED_ONE = N_LED'(1);

   mode_t            modeReg;
   dir_t             dirReg;
   dir_t             nextDir;
   logic [N_LED-1:0] patternReg;
   logic [N_LED-1:0] nextPattern;
   logic [N_LED-1:0] seedPattern;
   logic             stepReg;
   logic             reload;
   logic             tick;

   // Rotations are built bit by bit with modulo indexing so that a single-LED
   // build is legal and simply maps the lone bit onto itself.
   function automatic logic [N_LED-1:0] rotLeft(input logic [N_LED-1:0] v);
      logic [N_LED-1:0] r;
      for (int i = 0; i < N_LED; i++) begin
         r[i] = v[(i + N_LED - 1) % N_LED];
      end
      return r;
   endfunction

   function automatic logic [N_LED-1:0] rotRight(input logic [N_LED-1:0] v);
      logic [N_LED-1:0] r;
      for (int i = 0; i < N_LED; i++) begin
         r[i] = v[(i + 1) % N_LED];
      end
      return r;
   endfunction

   // A mode request that differs from the registered mode forces a reload;
   // the same signal restarts the timebase so the first step after a reload
   // lands a full period later.
   assign reload = (mode_i != modeReg);

   led_step_timer #(
      .TICK_DIV (TICK_DIV)
   ) stepTimer (
      .clk   (clk),
      .rst   (rst),
      .run   (run_i),
      .speed (speed_i),
      .clear (reload),
      .tick  (tick)
   );

   // Next-pattern logic for the registered mode. Bounce only ever holds one
   // lit bit and turns around before it would fall off an end, so rotating
   // is equivalent to shifting and needs no special end handling.
   always_comb begin
      nextPattern = patternReg;
      nextDir     = dirReg;
      seedPattern = (mode_i == MODE_BLINK) ? '1 : SEED_ONE;
      case (modeReg)
         MODE_ROT_L: nextPattern = rotLeft(patternReg);
         MODE_ROT_R: nextPattern = rotRight(patternReg);
         MODE_BOUNCE: begin
            if (dirReg == DIR_L && patternReg[N_LED-1]) begin
               nextDir     = DIR_R;
               nextPattern = rotRight(patternReg);
            end else if (dirReg == DIR_R && patternReg[0]) begin
               nextDir     = DIR_L;
               nextPattern = rotLeft(patternReg);
            end else if (dirReg == DIR_L) begin
               nextPattern = rotLeft(patternReg);
            end else begin
               nextPattern = rotRight(patternReg);
            end
         end
         MODE_BLINK: nextPattern = ~patternReg;
         default: nextPattern = patternReg;
      endcase
   end

   // Pattern state. A reload takes priority over a coincident tick and
   // suppresses the step pulse for that cycle; a reload also happens while
   // frozen since it does not depend on run_i.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         modeReg    <= MODE_ROT_L;
         dirReg     <= DIR_L;
         patternReg <= SEED_ONE;
         stepReg    <= 1'b0;
      end else if (reload) begin
         modeReg    <= mode_t'(mode_i);
         dirReg     <= DIR_L;
         patternReg <= seedPattern;
         stepReg    <= 1'b0;
      end else begin
         stepReg <= tick;
         if (tick) begin
            patternReg <= nextPattern;
            dirReg     <= nextDir;
         end
      end
   end

`ifdef LED_PATTERN_PWM_EN
   logic [PWM_W-1:0] pwmCnt;
   logic [N_LED-1:0] ledReg;
   logic             stepDly;

   // Brightness stage: a free-running counter gates the pattern, and the
   // step pulse is delayed by the same one register so it still lines up
   // with the visible LED change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwmCnt  <= '0;
         ledReg  <= SEED_ONE;
         stepDly <= 1'b0;
      end else begin
         pwmCnt  <= pwmCnt + PWM_W'(1);
         ledReg  <= patternReg & {N_LED{pwmCnt < duty_i}};
         stepDly <= stepReg;
      end
   end

   assign led_o  = ledReg;
   assign step_o = stepDly;
`else
   assign led_o  = patternReg;
   assign step_o = stepReg;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_gen
// Testbench for led_pattern_gen with N_LED=4, TICK_DIV=8. Stimulus queues the
// cycle and LED value of each expected step; an independent monitor pops one
// entry every time the DUT raises step_o and compares it.
// -----------------------------------------------------------------------------
module tb_led_pattern_gen;

   localparam int N_LED    = 4;
   localparam int TICK_DIV = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             run_i;
   logic [1:0]       mode_i;
   logic [1:0]       speed_i;
`ifdef LED_PATTERN_PWM_EN
   logic [7:0]       duty_i;
`endif
   logic [N_LED-1:0] led_o;
   logic             step_o;

   typedef struct {
      int         cycle;
      logic [3:0] led;
   } stepExp_t;

   stepExp_t expQ[$];
   int       cyc    = 0;
   int       checks = 0;
   int       errors = 0;

   led_pattern_gen #(
      .N_LED    (N_LED),
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .run_i   (run_i),
      .mode_i  (mode_i),
      .speed_i (speed_i),
`ifdef LED_PATTERN_PWM_EN
      .duty_i  (duty_i),
`endif
      .led_o   (led_o),
      .step_o  (step_o)
   );

   // 10 ns clock; inputs change and outputs are sampled on the falling edge.
   always #5 clk = ~clk;

   // Free-running cycle count used to timestamp expected steps.
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every observed step must match the oldest queued expectation
   // in both cycle number and LED value.
   always @(negedge clk) begin
      stepExp_t e;
      if (!rst && step_o) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpectedStep at cycle %0d led %b", cyc, led_o);
         end else begin
            e = expQ.pop_front();
            if (e.cycle != cyc || e.led != led_o) begin
               errors++;
               $display("[TB] FAIL step got cycle %0d led %b, expected cycle %0d led %b",
                        cyc, led_o, e.cycle, e.led);
            end
         end
      end
   end

   task automatic applyStimulus(input logic r, input logic [1:0] m, input logic [1:0] s);
      run_i   = r;
      mode_i  = m;
      speed_i = s;
   endtask

   task automatic checkOutput(input string name, input logic [3:0] expLed, input logic expStep);
      checks++;
      if (led_o !== expLed) begin
         errors++;
         $display("[TB] FAIL %s led got %b expected %b", name, led_o, expLed);
      end
      checks++;
      if (step_o !== expStep) begin
         errors++;
         $display("[TB] FAIL %s step got %b expected %b", name, step_o, expStep);
      end
   endtask

   task automatic expectStep(input int offset, input logic [3:0] led);
      stepExp_t e;
      e.cycle = cyc + offset;
      e.led   = led;
      expQ.push_back(e);
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

`ifdef LED_PATTERN_PWM_EN
   task automatic countHigh(input string name, input int expCount);
      int highs;
      highs = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         if (led_o[0]) highs++;
      end
      checks++;
      if (highs != expCount) begin
         errors++;
         $display("[TB] FAIL %s high cycles got %0d expected %0d", name, highs, expCount);
      end
   endtask
`endif

   initial begin
      applyStimulus(1'b1, 2'd0, 2'd0);
`ifdef LED_PATTERN_PWM_EN
      duty_i = 8'd64;
      run_i  = 1'b0;
`endif
      waitCycles(3);
      checkOutput("resetState", 4'b0001, 1'b0);
      rst = 1'b0;

`ifdef LED_PATTERN_PWM_EN
      $display("[TB] PWM build: duty checks with frozen pattern");
      waitCycles(4);
      countHigh("duty64", 64);
      duty_i = 8'd0;
      waitCycles(2);
      countHigh("duty0", 0);
      #2 rst = 1'b1;
      #1 checkOutput("asyncReset", 4'b0001, 1'b0);
      waitCycles(2);
`else
      // Rotate left from reset: first step at the 8th edge after release.
      expectStep(8,  4'b0010);
      expectStep(16, 4'b0100);
      expectStep(24, 4'b1000);
      expectStep(32, 4'b0001);
      waitCycles(32);

      // Bounce from seed, one step per 8 cycles, turning at both ends.
      applyStimulus(1'b1, 2'd2, 2'd0);
      waitCycles(1);
      checkOutput("bounceSeed", 4'b0001, 1'b0);
      expectStep(8,  4'b0010);
      expectStep(16, 4'b0100);
      expectStep(24, 4'b1000);
      expectStep(32, 4'b0100);
      expectStep(40, 4'b0010);
      expectStep(48, 4'b0001);
      expectStep(56, 4'b0010);
      waitCycles(56);

      // Back to rotate left at speed 2: period of 2 cycles.
      applyStimulus(1'b1, 2'd0, 2'd2);
      waitCycles(1);
      checkOutput("rotSeed", 4'b0001, 1'b0);
      expectStep(2, 4'b0010);
      expectStep(4, 4'b0100);
      expectStep(6, 4'b1000);
      expectStep(8, 4'b0001);
      waitCycles(8);

      // Speed 0 up to count 5, then speed 3: tick next edge, then every edge.
      applyStimulus(1'b1, 2'd0, 2'd0);
      waitCycles(5);
      applyStimulus(1'b1, 2'd0, 2'd3);
      expectStep(1, 4'b0010);
      expectStep(2, 4'b0100);
      expectStep(3, 4'b1000);
      expectStep(4, 4'b0001);
      waitCycles(4);

      // Freeze at count 3 for 20 cycles; resume reaches 7 four edges later.
      applyStimulus(1'b1, 2'd0, 2'd0);
      waitCycles(3);
      applyStimulus(1'b0, 2'd0, 2'd0);
      waitCycles(20);
      checkOutput("frozen", 4'b0001, 1'b0);
      applyStimulus(1'b1, 2'd0, 2'd0);
      expectStep(5, 4'b0010);
      waitCycles(12);

      // Count is 7 here, so the blink request coincides with a tick.
      applyStimulus(1'b1, 2'd3, 2'd0);
      waitCycles(1);
      checkOutput("blinkSeed", 4'b1111, 1'b0);
      expectStep(8,  4'b0000);
      expectStep(16, 4'b1111);
      waitCycles(16);

      // Asynchronous reset mid-run restores the seed without a clock edge.
      waitCycles(3);
      #2 rst = 1'b1;
      #1 checkOutput("asyncReset", 4'b0001, 1'b0);
      waitCycles(2);
`endif

      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL missingSteps got %0d pending expected 0", expQ.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
